lut_mask_loader: RTL and testbench

LUT_MASK_LOADER -- requirements
Module: lut_mask_loader

---
 rtl/lut_mask_loader.sv | 115 +++++++++++
 tb/tb_lut_mask_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_mask_loader.sv
// Serial loader that shifts N = 2**K configuration bits LSB first into a shadow register and commits them as a LUT mask.
// Optional macro LUT_MASK_LOADER_PARITY_EN adds a CHECK state that takes one even-parity bit before commit.
module lut_mask_loader #(
    parameter int K = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_start_i,
    input  logic        cfg_valid_i,
    input  logic        cfg_bit_i,
    output logic        cfg_ready_o,
    output logic [63:0] mask_o,
    output logic        mask_valid_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int N = 1 << K;
    localparam logic [5:0] LAST_IDX = 6'(N - 1);

`ifdef LUT_MASK_LOADER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, COMMIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic [63:0] shadow;
    logic        last_bit;
    logic        parity_bad;

    assign last_bit   = (cnt == LAST_IDX);
    // Shadow bits at and above N are never written, so the full-width XOR is the mask parity.
    assign parity_bad = (^shadow) ^ cfg_bit_i;
    assign busy_o     = (state != IDLE);

    always_comb begin
        state_next  = state;
        cfg_ready_o = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start_i) state_next = SHIFT;
            end
            SHIFT: begin
                cfg_ready_o = 1'b1;
                if (!cfg_start_i && cfg_valid_i && last_bit) begin
`ifdef LUT_MASK_LOADER_PARITY_EN
                    state_next = CHECK;
`else
                    state_next = COMMIT;
`endif
                end
            end
`ifdef LUT_MASK_LOADER_PARITY_EN
            CHECK: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) state_next = parity_bad ? IDLE : COMMIT;
            end
`endif
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 6'd0;
            shadow       <= 64'd0;
            mask_o       <= 64'd0;
            mask_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state <= state_next;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start_i) begin
                        cnt    <= 6'd0;
                        shadow <= 64'd0;
                    end
                end
                SHIFT: begin
                    // A start during a load wins over any bit offered in the same cycle.
                    if (cfg_start_i) begin
                        cnt    <= 6'd0;
                        shadow <= 64'd0;
                        err_o  <= 1'b1;
                    end else if (cfg_valid_i) begin
                        shadow[cnt] <= cfg_bit_i;
                        if (!last_bit) cnt <= cnt + 6'd1;
                    end
                end
`ifdef LUT_MASK_LOADER_PARITY_EN
                CHECK: begin
                    if (cfg_valid_i && parity_bad) err_o <= 1'b1;
                end
`endif
                COMMIT: begin
                    mask_o       <= shadow;
                    mask_valid_o <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_mask_loader.sv
// Directed bench for lut_mask_loader: four instances (K=2,3,4,6) share data/valid/reset, each with its own start.
module tb_lut_mask_loader;

    logic clk = 1'b0;
    logic reset;
    logic valid;
    logic bitv;
    logic [3:0] start_w;
    logic [3:0] ready_w, mvalid_w, busy_w, err_w;
    logic [3:0][63:0] mask_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lut_mask_loader #(.K(2)) u_k2 (.clk(clk), .reset(reset), .cfg_start_i(start_w[0]), .cfg_valid_i(valid),
        .cfg_bit_i(bitv), .cfg_ready_o(ready_w[0]), .mask_o(mask_w[0]), .mask_valid_o(mvalid_w[0]),
        .busy_o(busy_w[0]), .err_o(err_w[0]));
    lut_mask_loader #(.K(3)) u_k3 (.clk(clk), .reset(reset), .cfg_start_i(start_w[1]), .cfg_valid_i(valid),
        .cfg_bit_i(bitv), .cfg_ready_o(ready_w[1]), .mask_o(mask_w[1]), .mask_valid_o(mvalid_w[1]),
        .busy_o(busy_w[1]), .err_o(err_w[1]));
    lut_mask_loader #(.K(4)) u_k4 (.clk(clk), .reset(reset), .cfg_start_i(start_w[2]), .cfg_valid_i(valid),
        .cfg_bit_i(bitv), .cfg_ready_o(ready_w[2]), .mask_o(mask_w[2]), .mask_valid_o(mvalid_w[2]),
        .busy_o(busy_w[2]), .err_o(err_w[2]));
    lut_mask_loader #(.K(6)) u_k6 (.clk(clk), .reset(reset), .cfg_start_i(start_w[3]), .cfg_valid_i(valid),
        .cfg_bit_i(bitv), .cfg_ready_o(ready_w[3]), .mask_o(mask_w[3]), .mask_valid_o(mvalid_w[3]),
        .busy_o(busy_w[3]), .err_o(err_w[3]));

    typedef struct {
        int          idx;
        logic [63:0] data;
        bit          gaps;
        logic [63:0] exp;
    } vec_t;

    vec_t        vt[6];
    logic [63:0] prev[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int nb(input int idx);
        case (idx)
            0: return 4;
            1: return 8;
            2: return 16;
            default: return 64;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int idx);
        start_w[idx] = 1'b1;
        cyc();
        start_w[idx] = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [63:0] d, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                valid = 1'b0;
                cyc();
            end
            valid = 1'b1;
            bitv  = d[i];
            cyc();
        end
        valid = 1'b0;
        bitv  = 1'b0;
    endtask

`ifdef LUT_MASK_LOADER_PARITY_EN
    task automatic send_par(input logic p);
        valid = 1'b1;
        bitv  = p;
        cyc();
        valid = 1'b0;
        bitv  = 1'b0;
    endtask
`endif

    // Full load leaving the target instance in COMMIT; a correct even-parity bit is appended when enabled.
    task automatic load(input int idx, input logic [63:0] d, input bit gaps);
        do_start(idx);
        send_bits(nb(idx), d, gaps);
`ifdef LUT_MASK_LOADER_PARITY_EN
        send_par(^d);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) prev[i] = 64'd0;
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        bitv = 1'b0;
        start_w = 4'd0;
        vt[0] = '{2, 64'h0000_0000_0000_A5C3, 1'b0, 64'h0000_0000_0000_A5C3};
        vt[1] = '{3, 64'hFFFF_0000_8000_0001, 1'b1, 64'hFFFF_0000_8000_0001};
        vt[2] = '{0, 64'h0000_0000_0000_0009, 1'b0, 64'h0000_0000_0000_0009};
        vt[3] = '{1, 64'h0000_0000_0000_005A, 1'b1, 64'h0000_0000_0000_005A};
        vt[4] = '{2, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000};
        vt[5] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        cyc();
        do_reset();

        for (int i = 0; i < 4; i++) begin
            chk("rst_mask", mask_w[i], 64'd0);
            chk("rst_mvalid", {63'd0, mvalid_w[i]}, 64'd0);
            chk("rst_busy", {63'd0, busy_w[i]}, 64'd0);
            chk("rst_ready", {63'd0, ready_w[i]}, 64'd0);
            chk("rst_err", {63'd0, err_w[i]}, 64'd0);
        end

        for (int v = 0; v < 6; v++) begin
            load(vt[v].idx, vt[v].data, vt[v].gaps);
            chk("commit_ready", {63'd0, ready_w[vt[v].idx]}, 64'd0);
            chk("commit_busy", {63'd0, busy_w[vt[v].idx]}, 64'd1);
            chk("hold_mask", mask_w[vt[v].idx], prev[vt[v].idx]);
            cyc();
            chk("mask", mask_w[vt[v].idx], vt[v].exp);
            chk("mask_valid", {63'd0, mvalid_w[vt[v].idx]}, 64'd1);
            chk("busy_after", {63'd0, busy_w[vt[v].idx]}, 64'd0);
            chk("err_none", {63'd0, err_w[vt[v].idx]}, 64'd0);
            prev[vt[v].idx] = vt[v].exp;
        end

        // Restart mid-load: error pulse, old mask held, restart-cycle bit dropped.
        do_reset();
        load(2, 64'h00FF, 1'b0);
        cyc();
        chk("first_mask", mask_w[2], 64'h00FF);
        do_start(2);
        send_bits(7, 64'h1234, 1'b0);
        start_w[2] = 1'b1;
        valid = 1'b1;
        bitv = 1'b1;
        cyc();
        start_w[2] = 1'b0;
        valid = 1'b0;
        bitv = 1'b0;
        chk("restart_err", {63'd0, err_w[2]}, 64'd1);
        chk("restart_busy", {63'd0, busy_w[2]}, 64'd1);
        cyc();
        chk("restart_err_pulse", {63'd0, err_w[2]}, 64'd0);
        send_bits(15, 64'h1234, 1'b0);
        chk("restart_hold", mask_w[2], 64'h00FF);
        send_bits(1, 64'h0, 1'b0);
`ifdef LUT_MASK_LOADER_PARITY_EN
        send_par(^16'h1234);
`endif
        // Start held during COMMIT must not disturb the commit or raise an error.
        start_w[2] = 1'b1;
        cyc();
        start_w[2] = 1'b0;
        chk("restart_mask", mask_w[2], 64'h1234);
        chk("commit_start_err", {63'd0, err_w[2]}, 64'd0);
        chk("commit_start_idle", {63'd0, busy_w[2]}, 64'd0);

        // Reset mid-load clears a committed mask; valid in IDLE is ignored.
        do_reset();
        load(0, 64'h9, 1'b0);
        cyc();
        chk("k2_mask", mask_w[0], 64'h9);
        do_start(0);
        send_bits(2, 64'h2, 1'b0);
        reset = 1'b1;
        valid = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_mask", mask_w[0], 64'd0);
        chk("midrst_mvalid", {63'd0, mvalid_w[0]}, 64'd0);
        chk("midrst_busy", {63'd0, busy_w[0]}, 64'd0);
        bitv = 1'b1;
        cyc();
        cyc();
        chk("idle_valid_busy", {63'd0, busy_w[0]}, 64'd0);
        chk("idle_valid_ready", {63'd0, ready_w[0]}, 64'd0);
        chk("idle_valid_err", {63'd0, err_w[0]}, 64'd0);
        valid = 1'b0;
        bitv = 1'b0;
        load(0, 64'h6, 1'b0);
        cyc();
        chk("after_idle_mask", mask_w[0], 64'h6);

`ifdef LUT_MASK_LOADER_PARITY_EN
        do_reset();
        do_start(1);
        send_bits(8, 64'h07, 1'b0);
        chk("check_ready", {63'd0, ready_w[1]}, 64'd1);
        send_par(1'b1);
        cyc();
        chk("par_good_mask", mask_w[1], 64'h07);
        chk("par_good_err", {63'd0, err_w[1]}, 64'd0);
        load(1, 64'h03, 1'b0);
        cyc();
        chk("par_second_mask", mask_w[1], 64'h03);
        do_start(1);
        send_bits(8, 64'h07, 1'b0);
        send_par(1'b0);
        chk("par_bad_err", {63'd0, err_w[1]}, 64'd1);
        chk("par_bad_idle", {63'd0, busy_w[1]}, 64'd0);
        cyc();
        chk("par_bad_mask", mask_w[1], 64'h03);
        chk("par_bad_mvalid", {63'd0, mvalid_w[1]}, 64'd1);
        chk("par_bad_err_pulse", {63'd0, err_w[1]}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
